// File: rtl/fifo_read_port.sv
// Read-side controller for the synchronous FIFO: credit-based read strobes feeding a
// two-entry (head + skid) output buffer with a valid/ready handshake. FIFO_RD_CNT_EN adds rd_count.
module fifo_read_port #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_rd_en,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [15:0]           rd_count
`endif
);

   localparam int unsigned CREDIT_WIDTH = 3;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t                  occ;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] skid;
   logic                  pop;
   logic [CREDIT_WIDTH-1:0] credit;

   assign pop    = out_valid & out_ready;
   // Words held or arriving after this cycle's pop; a new read is allowed only below two.
   assign credit = CREDIT_WIDTH'(occ) + CREDIT_WIDTH'(inflight) - CREDIT_WIDTH'(pop);
   assign fifo_rd_en = reset & ~fifo_empty & (credit < CREDIT_WIDTH'(2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ       <= EMPTY;
         inflight  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         skid      <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (inflight) begin
            case (occ)
               EMPTY: begin
                  out_data  <= fifo_rdata;
                  out_valid <= 1'b1;
                  occ       <= ONE;
               end
               ONE: begin
                  if (pop) begin
                     out_data <= fifo_rdata;
                  end else begin
                     skid <= fifo_rdata;
                     occ  <= TWO;
                  end
               end
               TWO: begin
                  // Credit rule guarantees a pop whenever a word lands while full.
                  if (pop) begin
                     out_data <= skid;
                     skid     <= fifo_rdata;
                  end
               end
               default: begin
                  occ       <= EMPTY;
                  out_valid <= 1'b0;
               end
            endcase
         end else if (pop) begin
            case (occ)
               ONE: begin
                  occ       <= EMPTY;
                  out_valid <= 1'b0;
               end
               TWO: begin
                  out_data <= skid;
                  occ      <= ONE;
               end
               default: begin
                  occ       <= EMPTY;
                  out_valid <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef FIFO_RD_CNT_EN
   // Delivered-word counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_count <= '0;
      end else if (pop) begin
         rd_count <= rd_count + 16'd1;
      end
   end
`endif

endmodule
